led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised multi-channel LED pattern engine. It is the successor to the free-running blink counter.
- Sits between the PLL-derived system clock and the board LED pins.
- Divides the system clock to a configurable step rate and drives NUM_LEDS outputs.
- Four runtime-selectable modes: binary count, bounce scanner, PWM breathe, all-on.

Parameters:
NUM_LEDS, 8, number of LED outputs (>=1)
SYS_CLK_FREQ, 204_000_000, sysclk frequency in Hz
STEP_FREQ, 8, pattern steps per second; DIV = SYS_CLK_FREQ/STEP_FREQ, must be >=2 (elaboration error otherwise)
PWM_BITS, 8, brightness/PWM counter width
BREATHE_INC, 16, brightness change per step in BREATHE mode (1..2^PWM_BITS-1)

Ports:
sysclk  in  1  system clock; all logic on rising edge
resetn  in  1  asynchronous active-low reset; assertion is asynchronous, release is synchronised externally
enable  in  1  high = run; low = freeze prescaler and pattern state
mode    in  2  0 COUNT, 1 SCAN, 2 BREATHE, 3 ALLON
step    out 1  one-cycle pulse at each pattern step
leds    out NUM_LEDS  registered LED drive, 1 = lit

Behaviour:
- Reset (async, resetn=0): all state clears while reset is held.
  - prescaler=0, step=0, mode_q=COUNT, cnt=0.
  - scan pos=0, scan dir=up.
  - level=0, breathe dir=up, pwm_cnt=0.
  - leds=0.
- Prescaler: counts 0..DIV-1 while enable=1 and wraps to 0.
  - step=1 for exactly the cycle after prescaler==DIV-1.
  - enable=0 holds prescaler and step=0; leds hold their last value.
- Mode capture: mode is sampled into mode_q only on step cycles.
  - If the sampled value differs from mode_q, the new mode's state reinitialises on that step: cnt=0, pos=0/dir up, level=0/dir up.
  - The new mode takes effect on that step; no partial update of the old mode occurs.
- COUNT: cnt (NUM_LEDS bits) += 1 per step, wrapping all-ones -> 0. leds = cnt.
- SCAN: leds = one-hot(pos).
  - Each step, pos moves one position in dir.
  - At pos=NUM_LEDS-1 with dir up: dir flips and pos becomes NUM_LEDS-2 on the same step. The end LED is lit for one step only.
  - Symmetric at pos=0.
  - NUM_LEDS==1: pos stays 0, LED constantly lit.
- BREATHE: per step, level +=/-= BREATHE_INC with saturation.
  - On reaching 2^PWM_BITS-1, dir becomes down.
  - On reaching 0, dir becomes up.
  - pwm_cnt (PWM_BITS) free-runs every sysclk regardless of enable.
  - All leds = (pwm_cnt < level). level=0 gives fully off; max level gives on except one cycle per period.
- ALLON: leds = all ones; state registers hold.
- Latency: leds update one cycle after the step pulse (COUNT/SCAN/ALLON) and one cycle after pwm_cnt changes (BREATHE).
- enable deasserted mid-operation: no state is lost. Resuming continues from the held prescaler value.
- Simultaneous mode change and enable=0: the change is ignored until the next step.

Optional Feature:
LED_PATTERN_GAMMA_EN
- Defined: BREATHE compares pwm_cnt against gamma = (level*level) >> PWM_BITS. The result is a perceptually linear ramp; level 0 still maps to off.
- Undefined: linear compare against level. No multiplier is inferred.

Decomposition:
- Package led_pattern_pkg holds:
  - mode enum: MODE_COUNT=2'd0, MODE_SCAN=2'd1, MODE_BREATHE=2'd2, MODE_ALLON=2'd3.
  - divisor function computing DIV and its $clog2 width.
- Sub-module led_step_prescaler (sysclk, resetn, enable -> step) holds the divider. Remaining logic stays in the top.

Test Plan (SYS_CLK_FREQ=16, STEP_FREQ=4 so DIV=4; NUM_LEDS=4; PWM_BITS=4; BREATHE_INC=4):
1. Reset, then enable=1, mode=0 for 80 cycles -> step every 4th cycle; leds 0,1,2,...,15,0, each 1 cycle after step.
2. mode=1 -> leds 0001,0010,0100,1000,0100,0010,0001,0010; NUM_LEDS=1 variant -> leds constant 1.
3. mode=2 -> level 0,4,8,12,15,11,7,3,0,4. At level=4, leds high 4 of every 16 cycles. Saturation holds exactly at 15 and 0.
4. enable=0 for 50 cycles mid-COUNT at leds=5 -> no step, leds stay 5. Re-enable -> next step after remaining prescaler cycles, leds=6.
5. Change mode 0->3 between steps -> leds unchanged until next step, then 1111. Change back to 0 -> leds 0000 at the following step.
6. Assert resetn mid-BREATHE asynchronously (between clock edges) -> leds=0 and step=0 immediately. After release, COUNT starts from 0 on the first step, 4 cycles later.

Source files
------------

// File: rtl/led_pattern_pkg.sv
// Shared types and elaboration helpers for the LED pattern engine.
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_ALLON   = 2'd3
  } mode_e;

  function automatic int calc_div(input int sys_freq, input int step_freq);
    return sys_freq / step_freq;
  endfunction

  function automatic int div_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/led_step_prescaler.sv
// Divides sysclk down to a one-cycle step pulse every DIV enabled cycles.
module led_step_prescaler
  import led_pattern_pkg::*;
#(
  parameter int SYS_CLK_FREQ = 204_000_000,
  parameter int STEP_FREQ    = 8
) (
  input  logic sysclk,
  input  logic resetn,
  input  logic enable,
  output logic step
);

  localparam int DIV = calc_div(SYS_CLK_FREQ, STEP_FREQ);
  localparam int CW  = div_width(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("led_step_prescaler: SYS_CLK_FREQ/STEP_FREQ must be >= 2");
  end

  logic [CW-1:0] presc;

  // step is registered, so it rises the cycle after the counter sits at LAST.
  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      presc <= '0;
      step  <= 1'b0;
    end else begin
      step <= enable && (presc == LAST);
      if (enable) presc <= (presc == LAST) ? '0 : presc + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-mode LED pattern engine (count, bounce scan, PWM breathe, all-on).
// Define LED_PATTERN_GAMMA_EN to square the breathe level before the PWM compare.
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int NUM_LEDS     = 8,
  parameter int SYS_CLK_FREQ = 204_000_000,
  parameter int STEP_FREQ    = 8,
  parameter int PWM_BITS     = 8,
  parameter int BREATHE_INC  = 16
) (
  input  logic                sysclk,
  input  logic                resetn,
  input  logic                enable,
  input  logic [1:0]          mode,
  output logic                step,
  output logic [NUM_LEDS-1:0] leds
);

  localparam int PW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [PW-1:0]       POS_LAST = PW'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0] LVL_MAX  = '1;
  localparam logic [PWM_BITS:0]   INC      = (PWM_BITS + 1)'(BREATHE_INC);

  mode_e                mode_q, mode_n;
  logic [NUM_LEDS-1:0]  cnt_q, cnt_n;
  logic [PW-1:0]        pos_q, pos_n;
  logic                 scan_up_q, scan_up_n;
  logic [PWM_BITS-1:0]  level_q, level_n;
  logic                 bup_q, bup_n;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  cmp_level;
  logic [PWM_BITS:0]    sum;
  logic [NUM_LEDS-1:0]  leds_n;

  led_step_prescaler #(
    .SYS_CLK_FREQ(SYS_CLK_FREQ),
    .STEP_FREQ   (STEP_FREQ)
  ) u_presc (
    .sysclk(sysclk),
    .resetn(resetn),
    .enable(enable),
    .step  (step)
  );

`ifdef LED_PATTERN_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;
  assign level_sq  = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};
  assign cmp_level = level_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign cmp_level = level_q;
`endif

  always_comb begin
    mode_n    = mode_q;
    cnt_n     = cnt_q;
    pos_n     = pos_q;
    scan_up_n = scan_up_q;
    level_n   = level_q;
    bup_n     = bup_q;
    sum       = {1'b0, level_q} + INC;
    if (step) begin
      mode_n = mode_e'(mode);
      // A mode switch only reinitialises; the new pattern starts advancing next step.
      if (mode_n != mode_q) begin
        cnt_n     = '0;
        pos_n     = '0;
        scan_up_n = 1'b1;
        level_n   = '0;
        bup_n     = 1'b1;
      end else begin
        case (mode_n)
          MODE_COUNT: cnt_n = cnt_q + 1'b1;
          MODE_SCAN: begin
            if (NUM_LEDS == 1) begin
              pos_n = '0;
            end else if (scan_up_q) begin
              if (pos_q == POS_LAST) begin
                scan_up_n = 1'b0;
                pos_n     = pos_q - 1'b1;
              end else begin
                pos_n = pos_q + 1'b1;
              end
            end else begin
              if (pos_q == '0) begin
                scan_up_n = 1'b1;
                pos_n     = pos_q + 1'b1;
              end else begin
                pos_n = pos_q - 1'b1;
              end
            end
          end
          MODE_BREATHE: begin
            if (bup_q) begin
              if (sum >= {1'b0, LVL_MAX}) begin
                level_n = LVL_MAX;
                bup_n   = 1'b0;
              end else begin
                level_n = sum[PWM_BITS-1:0];
              end
            end else if ({1'b0, level_q} <= INC) begin
              level_n = '0;
              bup_n   = 1'b1;
            end else begin
              level_n = level_q - INC[PWM_BITS-1:0];
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Breathe uses the registered level/pwm so leds trail pwm_cnt by one cycle.
  always_comb begin
    leds_n = '0;
    case (mode_n)
      MODE_COUNT:   leds_n = cnt_n;
      MODE_SCAN:    leds_n = NUM_LEDS'(1) << pos_n;
      MODE_BREATHE: leds_n = {NUM_LEDS{pwm_cnt < cmp_level}};
      default:      leds_n = '1;
    endcase
  end

  always_ff @(posedge sysclk or negedge resetn) begin
    if (!resetn) begin
      mode_q    <= MODE_COUNT;
      cnt_q     <= '0;
      pos_q     <= '0;
      scan_up_q <= 1'b1;
      level_q   <= '0;
      bup_q     <= 1'b1;
      pwm_cnt   <= '0;
      leds      <= '0;
    end else begin
      mode_q    <= mode_n;
      cnt_q     <= cnt_n;
      pos_q     <= pos_n;
      scan_up_q <= scan_up_n;
      level_q   <= level_n;
      bup_q     <= bup_n;
      pwm_cnt   <= pwm_cnt + 1'b1;
      if (enable || step) leds <= leds_n;
    end
  end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench: expected leds are queued per step and checked one cycle after each step pulse.
module tb_led_pattern_gen;

  logic       sysclk = 1'b0;
  logic       resetn;
  logic       enable;
  logic [1:0] mode;
  logic       step;
  logic [3:0] leds;
  logic       step1;
  logic [0:0] leds1;
  logic       step2;
  logic [3:0] leds2;
  logic       en2   = 1'b1;
  logic [1:0] mode2 = 2'd2;

  int checks   = 0;
  int failures = 0;
  logic       mon_en = 1'b0;
  logic       b_done = 1'b0;
  logic [3:0] exp_q[$];
  logic [4:0] exp_b_q[$];

  always #5 sysclk = ~sysclk;

  led_pattern_gen #(.NUM_LEDS(4), .SYS_CLK_FREQ(16), .STEP_FREQ(4), .PWM_BITS(4), .BREATHE_INC(4)) dut (
    .sysclk(sysclk), .resetn(resetn), .enable(enable), .mode(mode), .step(step), .leds(leds));

  led_pattern_gen #(.NUM_LEDS(1), .SYS_CLK_FREQ(16), .STEP_FREQ(4), .PWM_BITS(4), .BREATHE_INC(4)) dut1 (
    .sysclk(sysclk), .resetn(resetn), .enable(enable), .mode(mode), .step(step1), .leds(leds1));

  // DIV=16 so each breathe level is held for one full PWM period.
  led_pattern_gen #(.NUM_LEDS(4), .SYS_CLK_FREQ(16), .STEP_FREQ(1), .PWM_BITS(4), .BREATHE_INC(4)) dut2 (
    .sysclk(sysclk), .resetn(resetn), .enable(en2), .mode(mode2), .step(step2), .leds(leds2));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic wait_empty(input string name, input int max_cycles);
    int n = 0;
    while (exp_q.size() != 0 && n < max_cycles) begin
      @(negedge sysclk);
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  task automatic wait_step(output int k);
    k = 0;
    do begin
      @(negedge sysclk);
      k++;
    end while (!step && k < 40);
  endtask

  // Main monitor: one expected value per step, compared the cycle after the pulse.
  initial begin
    forever begin
      @(negedge sysclk);
      if (resetn && step && mon_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_step", 1, 0);
        end else begin
          @(negedge sysclk);
          check("leds_after_step", leds, exp_q.pop_front());
        end
      end
    end
  end

  // Breathe monitor: lit-cycle count over each 16-cycle window equals the level.
  initial begin
    int n;
    int cnt;
    @(posedge resetn);
    n = 0;
    while (!step2 && n < 60) begin
      @(negedge sysclk);
      n++;
    end
    check("breathe_first_step", step2, 1);
    @(negedge sysclk);
    for (int w = 0; w < 10; w++) begin
      cnt = 0;
      repeat (16) begin
        @(negedge sysclk);
        if (leds2 == 4'hF) cnt++;
      end
      check("breathe_duty", cnt, exp_b_q.pop_front());
    end
    b_done = 1'b1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int stp_seen;
    int n;
    resetn = 1'b0;
    enable = 1'b0;
    mode   = 2'd0;
    repeat (3) @(negedge sysclk);
    check("reset_leds", leds, 0);
    check("reset_step", step, 0);
    check("reset_leds1", leds1, 0);

    foreach (exp_b_q[i]) exp_b_q.delete(i);
    exp_b_q.push_back(5'd0);  exp_b_q.push_back(5'd4);  exp_b_q.push_back(5'd8);
    exp_b_q.push_back(5'd12); exp_b_q.push_back(5'd15); exp_b_q.push_back(5'd11);
    exp_b_q.push_back(5'd7);  exp_b_q.push_back(5'd3);  exp_b_q.push_back(5'd0);
    exp_b_q.push_back(5'd4);

    // COUNT: 1..15, wrap to 0, then up to 4
    for (int i = 1; i <= 20; i++) exp_q.push_back(4'(i % 16));
    mon_en = 1'b1;
    resetn = 1'b1;
    enable = 1'b1;
    wait_empty("count", 200);

    // Freeze mid-COUNT right after leds become 5
    exp_q.push_back(4'd5);
    wait_step(k);
    @(negedge sysclk);
    enable = 1'b0;
    stp_seen = 0;
    repeat (50) begin
      @(negedge sysclk);
      if (step) stp_seen++;
    end
    check("freeze_steps", stp_seen, 0);
    check("freeze_leds", leds, 4'd5);
    exp_q.push_back(4'd6);
    enable = 1'b1;
    wait_step(k);
    check("resume_latency", k, 3);
    wait_empty("resume", 20);

    // COUNT -> ALLON -> COUNT
    exp_q.push_back(4'hF);
    mode = 2'd3;
    @(negedge sysclk);
    check("allon_hold", leds, 4'd6);
    wait_empty("allon", 20);
    exp_q.push_back(4'h0);
    exp_q.push_back(4'h1);
    exp_q.push_back(4'h2);
    mode = 2'd0;
    wait_empty("back_to_count", 30);

    // SCAN bounce
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010); exp_q.push_back(4'b0100);
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b0001); exp_q.push_back(4'b0010);
    mode = 2'd1;
    wait_empty("scan", 60);
    mon_en = 1'b0;
    repeat (8) begin
      @(negedge sysclk);
      check("scan_single_led", leds1, 1'b1);
    end

    n = 0;
    while (!b_done && n < 400) begin
      @(negedge sysclk);
      n++;
    end
    check("breathe_done", b_done, 1'b1);

    // Async reset mid-BREATHE, between clock edges
    mode = 2'd2;
    repeat (40) @(negedge sysclk);
    @(posedge sysclk);
    #2;
    resetn = 1'b0;
    #1;
    check("async_reset_leds", leds, 0);
    check("async_reset_step", step, 0);
    repeat (2) @(negedge sysclk);
    mode = 2'd0;
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd2);
    mon_en = 1'b1;
    resetn = 1'b1;
    wait_step(k);
    check("post_reset_latency", k, 4);
    wait_empty("post_reset", 20);

    repeat (2) @(negedge sysclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
